// File: rtl/m_exc_cp0_pkg.sv
// m_exc_cp0_pkg: shared exception codes, CP0 indices, bit positions and default address map
package m_exc_cp0_pkg;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;
  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 10;
  localparam int CAUSE_BD = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam logic [31:0] DEF_DM_TOP   = 32'h0000_2fff;
  localparam logic [31:0] DEF_DEV_BASE = 32'h0000_7f00;
  localparam logic [31:0] DEF_DEV_TOP  = 32'h0000_7f1b;
  localparam logic [31:0] DEF_PRID     = 32'h0000_0007;
  localparam logic [31:0] DEF_HANDLER  = 32'h0000_4180;
endpackage

// File: rtl/m_exc_cp0_addr_check.sv
// m_addr_check: combinational alignment/range classifier for loads (AdEL) and stores (AdES)
module m_addr_check
  import m_exc_cp0_pkg::*;
#(
  parameter logic [31:0] DM_TOP   = DEF_DM_TOP,
  parameter logic [31:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [31:0] DEV_TOP  = DEF_DEV_TOP
) (
  input  logic        i_bop,
  input  logic        i_hop,
  input  logic        i_wop,
  input  logic        i_loadop,
  input  logic        i_storeop,
  input  logic [31:0] i_addr,
  input  logic        i_addr_ov,
  output logic [4:0]  o_code
);
  logic w_in_dm, w_in_dev, w_fault;
  // the timer COUNT register sits at DEV_BASE+8 and cannot be stored to
  always_comb begin
    w_in_dm  = i_addr <= DM_TOP;
    w_in_dev = (i_addr >= DEV_BASE) && (i_addr <= DEV_TOP);
    w_fault  = (i_wop && i_addr[1:0] != 2'b00) || (i_hop && i_addr[0]) || i_addr_ov ||
               !(w_in_dm || w_in_dev) || ((i_bop || i_hop) && w_in_dev) ||
               (i_storeop && i_addr == DEV_BASE + 32'd8);
    o_code   = !w_fault ? EXC_INT : i_loadop ? EXC_ADEL : i_storeop ? EXC_ADES : EXC_INT;
  end
endmodule

// File: rtl/m_exc_cp0.sv
// m_exc_cp0: M-stage exception detection, CP0 register file and interrupt arbitration
module m_exc_cp0
  import m_exc_cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] DM_TOP    = DEF_DM_TOP,
  parameter logic [31:0] DEV_BASE  = DEF_DEV_BASE,
  parameter logic [31:0] DEV_TOP   = DEF_DEV_TOP,
  parameter logic [31:0] PRID      = DEF_PRID,
  parameter logic [31:0] HANDLER   = DEF_HANDLER
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_m_valid,
  input  logic [31:0]          i_m_pc,
  input  logic                 i_m_bd,
  input  logic [4:0]           i_exc_in,
  input  logic                 i_bop,
  input  logic                 i_hop,
  input  logic                 i_wop,
  input  logic                 i_loadop,
  input  logic                 i_storeop,
  input  logic [31:0]          i_addr,
  input  logic                 i_addr_ov,
  input  logic                 i_alu_ov,
  input  logic [NUM_HWINT-1:0] i_hwint,
  input  logic                 i_cp0_we,
  input  logic [4:0]           i_cp0_addr,
  input  logic [31:0]          i_cp0_wdata,
  input  logic                 i_eret,
  output logic [31:0]          o_cp0_rdata,
  output logic [31:0]          o_epc,
  output logic                 o_req,
  output logic [4:0]           o_exc_code_out
);
  logic [5:0]           r_im;
  logic                 r_exl, r_ie, r_bd;
  logic [NUM_HWINT-1:0] r_ip;
  logic [4:0]           r_exccode;
  logic [31:0]          r_epc;
  logic [4:0]           w_ac_code, w_code, w_req_code;
  logic                 w_int_req, w_exc_req;
  logic [31:0]          w_pc_al, w_epc_new, w_sr, w_cause;
  logic [5:0]           w_ip6;

  m_addr_check #(.DM_TOP(DM_TOP), .DEV_BASE(DEV_BASE), .DEV_TOP(DEV_TOP)) u_addr_check (
    .i_bop(i_bop), .i_hop(i_hop), .i_wop(i_wop), .i_loadop(i_loadop), .i_storeop(i_storeop),
    .i_addr(i_addr), .i_addr_ov(i_addr_ov), .o_code(w_ac_code)
  );

  // classify M instruction and arbitrate; interrupts use the live lines, not the registered IP
  always_comb begin
    w_code         = i_exc_in != 5'd0 ? i_exc_in : w_ac_code != 5'd0 ? w_ac_code : i_alu_ov ? EXC_OV : EXC_INT;
    o_exc_code_out = i_m_valid ? w_code : 5'd0;
    w_int_req      = |(i_hwint & r_im[NUM_HWINT-1:0]) && r_ie && !r_exl && i_m_valid;
    w_exc_req      = o_exc_code_out != 5'd0 && !r_exl;
    o_req          = w_int_req || w_exc_req;
    w_req_code     = w_int_req ? EXC_INT : o_exc_code_out;
    w_pc_al        = i_m_pc & ~32'h3;
    w_epc_new      = i_m_bd ? w_pc_al - 32'd4 : w_pc_al;
  end

  // register read mux; reads see state before any same-cycle write
  always_comb begin
    w_ip6       = 6'(r_ip);
    w_sr        = {16'b0, r_im, 8'b0, r_exl, r_ie};
    w_cause     = {r_bd, 15'b0, w_ip6, 3'b0, r_exccode, 2'b0};
    o_cp0_rdata = i_cp0_addr == CP0_SR    ? w_sr :
                  i_cp0_addr == CP0_CAUSE ? w_cause :
                  i_cp0_addr == CP0_EPC   ? r_epc :
                  i_cp0_addr == CP0_PRID  ? PRID : 32'd0;
    o_epc       = r_epc;
  end

  // CP0 state: a taken event overrides any mtc0/eret in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= '0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      r_ip <= i_hwint;
      if (o_req) begin
        r_exl     <= 1'b1;
        r_exccode <= w_req_code;
        r_bd      <= i_m_bd;
        r_epc     <= w_epc_new;
      end else begin
        if (i_eret) r_exl <= 1'b0;
        if (i_cp0_we && i_cp0_addr == CP0_SR) begin
          r_im  <= i_cp0_wdata[SR_IM_LO +: 6];
          r_exl <= i_cp0_wdata[SR_EXL];
          r_ie  <= i_cp0_wdata[SR_IE];
        end
        if (i_cp0_we && i_cp0_addr == CP0_EPC) r_epc <= i_cp0_wdata;
      end
    end
  end
endmodule

// File: tb/tb_m_exc_cp0.sv
// tb_m_exc_cp0: directed self-checking bench for m_exc_cp0
module tb_m_exc_cp0;
  import m_exc_cp0_pkg::*;
  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_bd, bop, hop, wop, loadop, storeop, addr_ov, alu_ov, cp0_we, eret;
  logic [31:0] m_pc, addr, cp0_wdata, cp0_rdata, epc;
  logic [4:0]  exc_in, cp0_addr, exc_code_out;
  logic [5:0]  hwint;
  logic        req;
  int          n_chk = 0;
  int          n_fail = 0;

  m_exc_cp0 dut (
    .clk(clk), .reset(reset), .i_m_valid(m_valid), .i_m_pc(m_pc), .i_m_bd(m_bd), .i_exc_in(exc_in),
    .i_bop(bop), .i_hop(hop), .i_wop(wop), .i_loadop(loadop), .i_storeop(storeop), .i_addr(addr),
    .i_addr_ov(addr_ov), .i_alu_ov(alu_ov), .i_hwint(hwint), .i_cp0_we(cp0_we), .i_cp0_addr(cp0_addr),
    .i_cp0_wdata(cp0_wdata), .i_eret(eret), .o_cp0_rdata(cp0_rdata), .o_epc(epc), .o_req(req),
    .o_exc_code_out(exc_code_out)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m_valid = 0; m_pc = 0; m_bd = 0; exc_in = 0; bop = 0; hop = 0; wop = 0; loadop = 0; storeop = 0;
    addr = 0; addr_ov = 0; alu_ov = 0; hwint = 0; cp0_we = 0; cp0_addr = 0; cp0_wdata = 0; eret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
    cp0_addr = a;
    #1;
    chk(tag, cp0_rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1; cp0_addr = a; cp0_wdata = d;
    step();
  endtask

  task automatic do_eret();
    eret = 1;
    step();
  endtask

  // address-classification table: ld=1 load / 0 store, sz 0=byte 1=half 2=word
  logic [31:0] t_addr [12] = '{32'h2ffc, 32'h3000, 32'h7f00, 32'h7f08, 32'h7f08, 32'h7f04,
                               32'h7f1c, 32'h7f18, 32'h0002, 32'h0003, 32'h0010, 32'h2fff};
  logic        t_ld   [12] = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 1, 1};
  logic [1:0]  t_sz   [12] = '{2, 2, 2, 2, 2, 0, 2, 2, 1, 1, 2, 0};
  logic        t_ov   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  logic [4:0]  t_exp  [12] = '{0, 4, 0, 5, 0, 4, 4, 0, 0, 5, 4, 0};

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_req", 32'(req), 0);
    rd("rst_idx0", 5'd0, 0);
    rd("rst_sr", CP0_SR, 0);
    rd("rst_cause", CP0_CAUSE, 0);
    chk("rst_epc", epc, 0);

    // misaligned word load
    m_valid = 1; m_pc = 32'h1000; loadop = 1; wop = 1; addr = 32'h2;
    #1;
    chk("adel_code", 32'(exc_code_out), 4);
    chk("adel_req", 32'(req), 1);
    step();
    rd("adel_cause", CP0_CAUSE, 32'h10);
    rd("adel_sr", CP0_SR, 32'h2);
    chk("adel_epc", epc, 32'h1000);
    do_eret();
    rd("eret_sr", CP0_SR, 0);

    // half store into device space from a delay slot
    m_valid = 1; m_pc = 32'h3010; m_bd = 1; storeop = 1; hop = 1; addr = 32'h7f04;
    #1;
    chk("ades_code", 32'(exc_code_out), 5);
    chk("ades_req", 32'(req), 1);
    step();
    chk("ades_epc", epc, 32'h300c);
    rd("ades_cause", CP0_CAUSE, 32'h8000_0014);
    do_eret();

    // carried-in code beats overflow
    m_valid = 1; m_pc = 32'h1100; exc_in = EXC_RI; alu_ov = 1;
    #1;
    chk("ri_code", 32'(exc_code_out), 10);
    step();
    rd("ri_cause", CP0_CAUSE, 32'h28);
    do_eret();

    // bubble with overflow: no code, no req, EPC untouched
    alu_ov = 1; m_pc = 32'h5555;
    #1;
    chk("bub_code", 32'(exc_code_out), 0);
    chk("bub_req", 32'(req), 0);
    step();
    chk("bub_epc", epc, 32'h1100);

    // ALU overflow alone
    m_valid = 1; alu_ov = 1; m_pc = 32'h1200;
    #1;
    chk("ov_code", 32'(exc_code_out), 12);
    step();
    do_eret();

    // with EXL set, classify addresses without taking events
    mtc0(CP0_SR, 32'h2);
    rd("exl_sr", CP0_SR, 32'h2);
    for (int i = 0; i < 12; i++) begin
      m_valid = 1; addr = t_addr[i]; loadop = t_ld[i]; storeop = !t_ld[i]; addr_ov = t_ov[i];
      bop = t_sz[i] == 0; hop = t_sz[i] == 1; wop = t_sz[i] == 2;
      #1;
      chk($sformatf("tab%0d_code", i), 32'(exc_code_out), 32'(t_exp[i]));
      chk($sformatf("tab%0d_req", i), 32'(req), 0);
      step();
    end
    do_eret();

    // Cause and PRId are not writable
    mtc0(CP0_CAUSE, 32'hffff_ffff);
    mtc0(CP0_PRID, 32'h0);
    rd("cause_ro", CP0_CAUSE, 32'h30);
    rd("prid_ro", CP0_PRID, 32'h7);

    // interrupt on line 0
    mtc0(CP0_SR, 32'h0000_0401);
    rd("int_sr0", CP0_SR, 32'h401);
    m_valid = 1; m_pc = 32'h2000; hwint = 6'b000001;
    #1;
    chk("int_req", 32'(req), 1);
    chk("int_code", 32'(exc_code_out), 0);
    step();
    rd("int_cause", CP0_CAUSE, 32'h400);
    rd("int_sr1", CP0_SR, 32'h403);
    chk("int_epc", epc, 32'h2000);
    m_valid = 1; m_pc = 32'h2100; hwint = 6'b000001;
    #1;
    chk("int_exl_block", 32'(req), 0);
    step();
    step();
    rd("int_cause_clr", CP0_CAUSE, 0);
    do_eret();
    rd("int_eret_sr", CP0_SR, 32'h401);

    // interrupt with same-cycle eret and mtc0: event wins
    m_valid = 1; m_pc = 32'h2400; hwint = 6'b000001; eret = 1; cp0_we = 1; cp0_addr = CP0_EPC; cp0_wdata = 32'hdead_beef;
    #1;
    chk("int_eret_req", 32'(req), 1);
    step();
    rd("int_eret_sr1", CP0_SR, 32'h403);
    chk("int_eret_epc", epc, 32'h2400);
    do_eret();

    // reset in the cycle after a taken event
    m_valid = 1; m_pc = 32'h1300; alu_ov = 1;
    #1;
    chk("pre_rst_req", 32'(req), 1);
    step();
    reset = 1;
    step();
    reset = 0;
    rd("post_rst_sr", CP0_SR, 0);
    rd("post_rst_cause", CP0_CAUSE, 0);
    rd("post_rst_epc", CP0_EPC, 0);
    rd("post_rst_prid", CP0_PRID, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
